// File: rtl/f1_pkg.sv
// f1_pkg: shared widths, FIFO occupancy states and the reference position decode
package f1_pkg;
  localparam int W_DEF = 32;
  function automatic int pos_w(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int PW_DEF = pos_w(W_DEF);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;
  function automatic logic [W_DEF:0] decode_pos(input logic [PW_DEF-1:0] pos, input logic mask);
    logic err;
    logic [W_DEF-1:0] d;
    err = pos > PW_DEF'(W_DEF);
    d = err ? '0 : mask ? ~({W_DEF{1'b1}} << pos) : (pos == '0) ? '0 : W_DEF'(1) << (pos - PW_DEF'(1));
    return {err, d};
  endfunction
endpackage

// File: rtl/f1_sync_fifo.sv
// f1_sync_fifo: small synchronous FIFO whose head reads as zero when empty
module f1_sync_fifo
  import f1_pkg::*;
#(
  parameter int WD = 33,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [WD-1:0] din_i,
  input  logic          pop_i,
  output logic [WD-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WD-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  fifo_state_e state;
  // occupancy state from pointers: equal means empty, MSBs differing with equal index means full
  always_comb begin
    state = (wr_q == rd_q) ? EMPTY : (wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0]) ? FULL : PARTIAL;
    full_o = state == FULL;
    empty_o = state == EMPTY;
    wr_d = push_i ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop_i ? rd_q + (AW+1)'(1) : rd_q;
    dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end
  // pointer registers, cleared on reset so queued entries are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage write at the tail
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/first1_pos_decoder.sv
// first1_pos_decoder: position code to one-hot/mask word, queued behind a valid/ready port
module first1_pos_decoder
  import f1_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DEPTH = 2,
  localparam int PW = pos_w(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  input  logic          in_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_err,
  output logic [15:0]   dec_count
);
  logic [W-1:0] dec_data;
  logic dec_err, push, pop, full, empty;
  logic [15:0] dec_count_q, dec_count_d;
  // decode and handshake; a full FIFO still accepts when the head is taken the same cycle
  always_comb begin
    dec_err = in_pos > PW'(W);
    dec_data = dec_err ? '0 : in_mask ? ~({W{1'b1}} << in_pos) : (in_pos == '0) ? '0 : W'(1) << (in_pos - PW'(1));
    out_valid = !empty;
    in_ready = !full || out_ready;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    dec_count_d = push ? dec_count_q + 16'd1 : dec_count_q;
    dec_count = dec_count_q;
  end
  // accepted-request counter, wraps silently
  always_ff @(posedge clk) begin
    if (rst) dec_count_q <= '0;
    else dec_count_q <= dec_count_d;
  end
  f1_sync_fifo #(.WD(W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .din_i({dec_err, dec_data}),
    .pop_i(pop),
    .dout_o({out_err, out_data}),
    .full_o(full),
    .empty_o(empty)
  );
endmodule
